// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: pipeline writeback has priority, aux results queue in a FIFO
// and drain into idle cycles, with a starvation guard and drain sequence. Trace: WB_TRACE_EN.
module grf_wb_arbiter #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p_we,
  input  logic [4:0]  p_addr,
  input  logic [31:0] p_data,
  input  logic [31:0] p_pc,
  output logic        p_stall,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic [31:0] a_pc,
  input  logic        drain_req,
  output logic        drain_done,
  input  logic [4:0]  q_addr,
  output logic        q_busy,
  output logic [5:0]  wr_addr,
  output logic [31:0] wr_data,
  output logic [31:0] wr_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_MAX) + 1;

  typedef enum logic [1:0] {NORM, FORCE, DRAIN} state_t;

  state_t         state, state_nx;
  logic [4:0]     f_addr [DEPTH];
  logic [31:0]    f_data [DEPTH];
  logic [31:0]    f_pc   [DEPTH];
  logic [AW-1:0]  rptr, wptr, idx;
  logic [AW:0]    count;
  logic [CW-1:0]  starve;
  logic           alive;
  logic           empty, full, push, pop, gnt_p;
  logic [5:0]     g_addr;
  logic [31:0]    g_data, g_pc;

  assign empty      = (count == '0);
  assign full       = (count == (AW+1)'(DEPTH));
  // alive holds a_ready/drain_done low until the first edge after reset release
  assign a_ready    = alive && !full && (state != DRAIN);
  assign drain_done = alive && (state == NORM) && empty;
  assign push       = a_valid && a_ready && (a_addr != '0);

  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    gnt_p    = 1'b0;
    p_stall  = 1'b0;
    case (state)
      NORM: begin
        if (p_we && p_addr != '0) gnt_p = 1'b1;
        else if (!empty)          pop   = 1'b1;
        if (drain_req && !empty)
          state_nx = DRAIN;
        else if (starve == CW'(STARVE_MAX - 1) && !empty && !pop)
          state_nx = FORCE;
      end
      FORCE: begin
        p_stall  = 1'b1;
        pop      = !empty;
        state_nx = NORM;
      end
      DRAIN: begin
        p_stall = 1'b1;
        pop     = !empty;
        if (count <= (AW+1)'(1)) state_nx = NORM;
      end
      default: state_nx = NORM;
    endcase
  end

  always_comb begin
    g_addr = '0;
    g_data = '0;
    g_pc   = '0;
    if (pop) begin
      g_addr = {1'b0, f_addr[rptr]};
      g_data = f_data[rptr];
      g_pc   = f_pc[rptr];
    end else if (gnt_p) begin
      g_addr = {1'b0, p_addr};
      g_data = p_data;
      g_pc   = p_pc;
    end
  end

  always_comb begin
    q_busy = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rptr + AW'(k);
      if ((AW+1)'(k) < count && f_addr[idx] == q_addr && q_addr != '0)
        q_busy = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= NORM;
      rptr    <= '0;
      wptr    <= '0;
      count   <= '0;
      starve  <= '0;
      alive   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_pc   <= '0;
    end else begin
      state   <= state_nx;
      alive   <= 1'b1;
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      count   <= count + (AW+1)'(push) - (AW+1)'(pop);
      starve  <= (!empty && !pop) ? starve + CW'(1) : '0;
      wr_addr <= g_addr;
      wr_data <= g_data;
      wr_pc   <= g_pc;
`ifdef WB_TRACE_EN
      if (g_addr != '0) $display("@%h: $%0d <= %h", g_pc, g_addr, g_data);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      f_addr[wptr] <= a_addr;
      f_data[wptr] <= a_data;
      f_pc[wptr]   <= a_pc;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Randomized bench for grf_wb_arbiter against a queue-based reference model.
module tb_grf_wb_arbiter;
  localparam int DEPTH      = 4;
  localparam int STARVE_MAX = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_we, a_valid, drain_req;
  logic [4:0]  p_addr, a_addr, q_addr;
  logic [31:0] p_data, p_pc, a_data, a_pc;
  logic        p_stall, a_ready, drain_done, q_busy;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data, wr_pc;

  always #5 clk = ~clk;

  grf_wb_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .p_we(p_we), .p_addr(p_addr), .p_data(p_data), .p_pc(p_pc), .p_stall(p_stall),
    .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data), .a_pc(a_pc),
    .drain_req(drain_req), .drain_done(drain_done),
    .q_addr(q_addr), .q_busy(q_busy),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_pc(wr_pc)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic [31:0] pc;
  } ent_t;

  ent_t        mq[$];
  int          starve;
  bit          forcing, draining, alive;
  logic [5:0]  e_wa;
  logic [31:0] e_wd, e_wp;
  int          npass = 0;
  int          ntot  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic void model_reset();
    mq.delete();
    starve   = 0;
    forcing  = 0;
    draining = 0;
    alive    = 0;
    e_wa     = '0;
    e_wd     = '0;
    e_wp     = '0;
  endfunction

  function automatic bit m_ready();
    return alive && (mq.size() < DEPTH) && !draining;
  endfunction

  function automatic bit m_busy();
    if (q_addr == 0) return 0;
    foreach (mq[i]) if (mq[i].a == q_addr) return 1;
    return 0;
  endfunction

  task automatic tick();
    ent_t h, n;
    int   pre;
    bit   popped, rdy;
    @(negedge clk);
    if (!rst_n) model_reset();
    chk("wr_addr",    wr_addr,    e_wa);
    chk("wr_data",    wr_data,    e_wd);
    chk("wr_pc",      wr_pc,      e_wp);
    chk("a_ready",    a_ready,    m_ready());
    chk("p_stall",    p_stall,    forcing || draining);
    chk("drain_done", drain_done, alive && !forcing && !draining && mq.size() == 0);
    chk("q_busy",     q_busy,     m_busy());
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      pre    = mq.size();
      rdy    = m_ready();
      popped = 0;
      e_wa = '0; e_wd = '0; e_wp = '0;
      if (forcing || draining) begin
        if (pre > 0) begin h = mq.pop_front(); popped = 1; end
      end else if (p_we && p_addr != 0) begin
        e_wa = {1'b0, p_addr}; e_wd = p_data; e_wp = p_pc;
      end else if (pre > 0) begin
        h = mq.pop_front(); popped = 1;
      end
      if (popped) begin e_wa = {1'b0, h.a}; e_wd = h.d; e_wp = h.pc; end
      if (a_valid && rdy && a_addr != 0) begin
        n.a = a_addr; n.d = a_data; n.pc = a_pc;
        mq.push_back(n);
      end
      if (draining)      draining = (mq.size() != 0);
      else if (forcing)  forcing  = 0;
      else if (drain_req && pre > 0) draining = 1;
      else if (starve == STARVE_MAX - 1 && pre > 0 && !popped) forcing = 1;
      starve = (pre > 0 && !popped) ? starve + 1 : 0;
      alive  = 1;
    end
    #1;
  endtask

  task automatic set_p(input logic we, input logic [4:0] ad, input logic [31:0] d, input logic [31:0] pc);
    p_we = we; p_addr = ad; p_data = d; p_pc = pc;
  endtask

  task automatic set_a(input logic v, input logic [4:0] ad, input logic [31:0] d, input logic [31:0] pc);
    a_valid = v; a_addr = ad; a_data = d; a_pc = pc;
  endtask

  task automatic idle();
    set_p(0, 0, 0, 0);
    set_a(0, 0, 0, 0);
    drain_req = 0;
  endtask

  int pw, pa, pd;

  initial begin
    rst_n = 0;
    q_addr = 0;
    idle();
    model_reset();
    repeat (3) tick();
    rst_n = 1;
    repeat (2) tick();

    // pipeline-only writes, including register 0
    set_p(1, 5, 32'h1234, 32'h3000); tick();
    set_p(1, 0, 32'hdead, 32'h3004); tick();
    idle(); tick();

    // fill FIFO behind a busy pipeline, then let it drain in idle cycles
    q_addr = 9;
    for (int i = 0; i < 6; i++) begin
      set_p(1, 5'(20 + i), 32'h100 + i, 32'h4000 + 4 * i);
      if (i < 4) set_a(1, 5'(8 + i), 32'hA00 + i, 32'h5000 + 4 * i); else set_a(0, 0, 0, 0);
      tick();
    end
    idle();
    repeat (7) tick();

    // starvation guard
    set_p(1, 3, 32'h33, 32'h6000);
    set_a(1, 12, 32'hC12, 32'h6100);
    q_addr = 12;
    tick();
    set_a(0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      set_p(1, 5'(1 + i), 32'h700 + i, 32'h7000 + 4 * i);
      tick();
    end
    idle(); tick();

    // drain with three queued entries
    for (int i = 0; i < 3; i++) begin
      set_p(1, 5'(4 + i), 32'h800 + i, 32'h8000 + 4 * i);
      set_a(1, 5'(13 + i), 32'hD00 + i, 32'h8100 + 4 * i);
      tick();
    end
    set_a(0, 0, 0, 0);
    set_p(1, 7, 32'h807, 32'h800c);
    drain_req = 1; tick();
    drain_req = 0;
    set_a(1, 17, 32'hE17, 32'h8200);
    repeat (5) tick();
    idle(); tick();

    // simultaneous push/pop with one entry, then aux write to r0
    set_a(1, 18, 32'hF18, 32'h9000); tick();
    set_a(1, 19, 32'hF19, 32'h9004); tick();
    set_a(1, 0,  32'hF00, 32'h9008); tick();
    idle(); repeat (3) tick();

    // reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      set_p(1, 5'(21 + i), 32'h900 + i, 32'hA000 + 4 * i);
      set_a(1, 5'(24 + i), 32'hB00 + i, 32'hA100 + 4 * i);
      tick();
    end
    set_a(0, 0, 0, 0);
    drain_req = 1; tick();
    drain_req = 0; tick();
    rst_n = 0; tick();
    rst_n = 1; idle();
    repeat (3) tick();

    // randomized traffic with shifting load profiles
    for (int ph = 0; ph < 6; ph++) begin
      pw = $urandom_range(10, 95);
      pa = $urandom_range(10, 90);
      pd = $urandom_range(0, 6);
      for (int c = 0; c < 500; c++) begin
        set_p($urandom_range(0, 99) < pw, 5'($urandom_range(0, 31)), $urandom, $urandom);
        set_a($urandom_range(0, 99) < pa, 5'($urandom_range(0, 31)), $urandom, $urandom);
        drain_req = $urandom_range(0, 99) < pd;
        q_addr    = 5'($urandom_range(0, 31));
        rst_n     = ($urandom_range(0, 499) != 0);
        tick();
      end
    end
    rst_n = 1;
    idle();
    repeat (4) tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
